vga_image_reader: RTL and testbench

Read-side counterpart to the processor's image-memory writes. Generates 640x480@60 VGA timing from the 50 MHz system clock and scans the 8-bit grayscale processed-image memory through its read port. Drives the same value on R/G/B for the ADV7123 DAC. The memory-mapped `vga` show flag gates display per frame.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_image_reader_if.sv | 16 +
 rtl/vga_timing.sv | 53 +++++
 rtl/vga_image_reader.sv | 123 ++++++++++++
 tb/tb_vga_image_reader.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants shared by the image reader and its timing
// generator, plus the bring-up gray-bar helper used when VGA_TEST_PATTERN_EN
// is defined.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = 525;

    // Sync pulse windows, inclusive bounds on the counter values.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int CNT_W = 10;
    localparam int BAR_W = 80;

    // Gray level of the 80 px wide vertical bar containing column h.
    // Threshold compares instead of a divide so it stays a few comparators.
    function automatic logic [7:0] bar_level(input logic [CNT_W-1:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i * BAR_W)) idx = 3'(i);
        end
        return {idx, 5'b0};
    endfunction

endpackage

// File: rtl/vga_image_reader_if.sv
// Image memory read port between the VGA reader (master) and the
// processed-image RAM (slave).
//
// Handshake: there is no valid/ready pair. The master presents
// mem_rd_adr every clk; the slave returns mem_rd_data for that address
// exactly one clk later (synchronous RAM read). The master never stalls
// and never writes.
interface vga_image_reader_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_rd_adr;
    logic [7:0]        mem_rd_data;

    modport master (output mem_rd_adr, input  mem_rd_data);
    modport slave  (input  mem_rd_adr, output mem_rd_data);
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 timing generator: 25 MHz pixel tick from the 50 MHz clock,
// horizontal/vertical counters and combinational sync/active/frame-end
// decode (pipeline stage 0).
module vga_timing
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             tick,
    output logic             hsync_c,
    output logic             vsync_c,
    output logic             active_c,
    output logic             frame_end
);

    logic pix_tick;
    logic h_last;
    logic v_last;

    // Divide-by-two pixel enable; counters move only on clks where it is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pix_tick <= 1'b0;
        else        pix_tick <= ~pix_tick;
    end

    assign tick   = pix_tick;
    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Raster counters: h wraps at 799 and carries into v, v wraps at 524.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Pin levels (syncs are active-low) decoded straight from the counters.
    assign hsync_c   = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt <= CNT_W'(H_SYNC_END)));
    assign vsync_c   = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt <= CNT_W'(V_SYNC_END)));
    assign active_c  = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign frame_end = tick && h_last && v_last;

endmodule

// File: rtl/vga_image_reader.sv
// VGA image reader: scans the 8-bit grayscale image memory in raster order
// and drives the ADV7123 with R=G=B. Display is gated per frame by `show`.
// Optional build macro VGA_TEST_PATTERN_EN: gray bars in the active area
// while the frame's show latch is 0.
module vga_image_reader
    import vga_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               show,
    vga_image_reader_if.master mem,
    output logic               vga_clk,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               frame_done
);

    localparam logic [ADDR_W-1:0] ADR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              tick;
    logic              hsync_c;
    logic              vsync_c;
    logic              active_c;
    logic              frame_end;
    logic              in_img;
    logic              frame_start;
    logic              show_q;
    logic              show_eff;
    logic [ADDR_W-1:0] adr_cnt;
    logic [7:0]        pix_d;
    logic [7:0]        pix_q;

    vga_timing u_timing (
        .clk       (clk),
        .reset     (reset),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .tick      (tick),
        .hsync_c   (hsync_c),
        .vsync_c   (vsync_c),
        .active_c  (active_c),
        .frame_end (frame_end)
    );

    assign in_img      = (int'(h_cnt) < IMG_W) && (int'(v_cnt) < IMG_H);
    assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
    // Pixel (0,0) is registered on the same tick that latches show, so it
    // uses the incoming value; the rest of the frame uses the latch.
    assign show_eff    = frame_start ? show : show_q;

    // Per-frame show latch: mid-frame changes wait for the next (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           show_q <= 1'b0;
        else if (frame_start) show_q <= show;
    end

    // Running raster address; saturates on the last image pixel and holds
    // outside the image, so no multiplier is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 adr_cnt <= '0;
        else if (frame_end)                         adr_cnt <= '0;
        else if (tick && in_img && adr_cnt != ADR_LAST) adr_cnt <= adr_cnt + 1'b1;
    end

    assign mem.mem_rd_adr = adr_cnt;

    // Pixel value for the current counters; memory data for this address
    // has been valid for one clk by the time the output stage samples it.
    always_comb begin
        pix_d = 8'h00;
        if (active_c && in_img && show_eff) begin
            pix_d = mem.mem_rd_data;
        end
`ifdef VGA_TEST_PATTERN_EN
        else if (active_c && !show_eff) begin
            pix_d = bar_level(h_cnt);
        end
`endif
    end

    // Output stage: one pixel of latency, syncs/blank/rgb move together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            pix_q       <= 8'h00;
        end else if (tick) begin
            vga_hsync   <= hsync_c;
            vga_vsync   <= vsync_c;
            vga_blank_n <= active_c;
            pix_q       <= pix_d;
        end
    end

    // DAC clock is the registered pixel tick; frame_done is a 1-clk pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_clk    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vga_clk    <= tick;
            frame_done <= frame_end;
        end
    end

    assign vga_r      = pix_q;
    assign vga_g      = pix_q;
    assign vga_b      = pix_q;
    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_image_reader.sv
// Bench for vga_image_reader: two instances (full 256x256 image and a small
// 32x4 image that reaches address saturation early) share clock, reset and
// show; every clk both are compared with a raster model computed from the
// elapsed clock count since reset release.
module tb_vga_image_reader;

    localparam int AW        = 16;
    localparam int FRAME_PIX = 800 * 525;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic show  = 1'b0;

    always #10 clk = ~clk;

    // ---------------- DUTs and memory models ----------------
    logic          vclk[2];
    logic          hs[2];
    logic          vs[2];
    logic          bl[2];
    logic          sn[2];
    logic          fd[2];
    logic [7:0]    r[2];
    logic [7:0]    g[2];
    logic [7:0]    b[2];
    logic [AW-1:0] adr_o[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 256 : 32;
        localparam int H = (gi == 0) ? 256 : 4;

        vga_image_reader_if #(.ADDR_W(AW)) bus ();

        vga_image_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
            .clk         (clk),
            .reset       (reset),
            .show        (show),
            .mem         (bus),
            .vga_clk     (vclk[gi]),
            .vga_hsync   (hs[gi]),
            .vga_vsync   (vs[gi]),
            .vga_blank_n (bl[gi]),
            .vga_sync_n  (sn[gi]),
            .vga_r       (r[gi]),
            .vga_g       (g[gi]),
            .vga_b       (b[gi]),
            .frame_done  (fd[gi])
        );

        // Synchronous image RAM: data = adr[15:8] ^ adr[7:0], one clk later.
        always_ff @(posedge clk) begin
            bus.mem_rd_data <= bus.mem_rd_adr[15:8] ^ bus.mem_rd_adr[7:0];
        end

        assign adr_o[gi] = bus.mem_rd_adr;
    end

    // ---------------- scoreboard state ----------------
    int   k           = 0;     // clk edges since reset release
    logic fshow       = 1'b0;  // show value latched for the current frame
    int   vectors     = 0;
    int   miscompares = 0;
    int   hs_low      = 0;
    int   bl_hi       = 0;
    int   fall_cnt    = 0;
    int   fall_k0     = 0;
    int   fall_k1     = 0;
    logic hs_prev     = 1'b1;

    function automatic int img_w(input int d);
        return (d == 0) ? 256 : 32;
    endfunction

    function automatic int img_h(input int d);
        return (d == 0) ? 256 : 4;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%h expected=%h", tag, k, got, exp);
        end
    endtask

    function automatic logic [45:0] obs(input int d);
        return {vclk[d], hs[d], vs[d], bl[d], sn[d], r[d], g[d], b[d], fd[d], adr_o[d]};
    endfunction

    // Expected pins after edge kk. Counters sit on raster position kk/2;
    // the pins show position kk/2-1 (one pixel behind).
    function automatic logic [45:0] model(input int kk, input int w, input int hi, input logic fs);
        int          n, p, hp, vp, hq, vq, adr_q;
        logic        vc, hs_e, vs_e, bl_e, fd_e;
        logic [7:0]  px;
        logic [15:0] a16;
        if (kk == 0) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 16'h0};
        vc = ((kk - 1) % 2) == 1;
        n  = kk / 2;
        hq = n % 800;
        vq = (n / 800) % 525;
        // Image pixels passed so far in this frame, saturated at the last one.
        if (vq < hi) adr_q = vq * w + ((hq < w) ? hq : w);
        else         adr_q = w * hi - 1;
        if (adr_q > w * hi - 1) adr_q = w * hi - 1;
        hs_e = 1'b1; vs_e = 1'b1; bl_e = 1'b0; px = 8'h00; fd_e = 1'b0;
        if (n > 0) begin
            p    = n - 1;
            hp   = p % 800;
            vp   = (p / 800) % 525;
            hs_e = !(hp >= 656 && hp < 752);
            vs_e = !(vp >= 490 && vp < 492);
            bl_e = (hp < 640) && (vp < 480);
            a16  = 16'(vp * w + hp);
            if (bl_e && hp < w && vp < hi && fs) px = a16[15:8] ^ a16[7:0];
`ifdef VGA_TEST_PATTERN_EN
            else if (bl_e && !fs) px = 8'((hp / 80) * 32);
`endif
            fd_e = (kk % 2 == 0) && ((p % FRAME_PIX) == FRAME_PIX - 1);
        end
        return {vc, hs_e, vs_e, bl_e, 1'b0, px, px, px, fd_e, 16'(adr_q)};
    endfunction

    // ---------------- driver: one clk, then check at the negedge ----------------
    task automatic step();
        int p, hp, vp, hq, vq;
        @(posedge clk);
        if (reset) k++;
        @(negedge clk);
        if (reset && k >= 2 && (k % 2 == 0) && (((k / 2 - 1) % FRAME_PIX) == 0)) fshow = show;
        for (int d = 0; d < 2; d++) begin
            check((d == 0) ? "pins_a" : "pins_b", 64'(obs(d)), 64'(model(k, img_w(d), img_h(d), fshow)));
        end
        if (reset && k >= 2) begin
            p  = k / 2 - 1;
            hp = p % 800;
            vp = (p / 800) % 525;
            hq = (k / 2) % 800;
            vq = (k / 2 / 800) % 525;
            if (k % 2 == 0) begin
                if (hq == 5 && vq == 3)   check("adr_5_3", 64'(adr_o[0]), 64'd773);
                if (hp == 5 && vp == 3)   check("rgb_5_3", 64'({r[0], g[0], b[0]}), fshow ? 64'h060606 : 64'h0);
                if (hp == 300 && vp == 3) check("blank_rgb_300_3", 64'({bl[0], r[0]}), 64'h100);
                if (hp == 10 && vp == 6)  check("b_below_img", 64'({bl[1], r[1]}), 64'h100);
                if (hq == 0 && vq == 10)  check("b_adr_hold", 64'(adr_o[1]), 64'd127);
            end
            if (vp == 4) begin
                if (!hs[0]) hs_low++;
                if (bl[0])  bl_hi++;
            end
            if (hs_prev && !hs[0]) begin
                if (fall_cnt == 0)      fall_k0 = k;
                else if (fall_cnt == 1) fall_k1 = k;
                fall_cnt++;
            end
        end
        hs_prev = hs[0];
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   vr;
        int   hr;
        logic found;

        // Reset hold: all pins at reset values.
        reset = 1'b0;
        show  = 1'b0;
        repeat (5) step();

        // Frame with show=0 at (0,0); show rises during row 2 and must not
        // display anything in this frame.
        reset = 1'b1;
        vr    = $urandom_range(5, 7);
        hr    = $urandom_range(0, 799);
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            step();
            if (k / 2 == 2 * 800 + hr) show = 1'b1;
            if ((k % 2 == 0) && ((k / 2) % 800 == 400) && ((k / 2) / 800 == vr)) found = 1'b1;
        end
        check("midline_found", 64'(found), 64'd1);

        // Mid-line asynchronous reset: pins must drop immediately.
        reset = 1'b0;
        #1;
        k     = 0;
        fshow = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("async_reset", 64'(obs(d)), 64'(model(0, img_w(d), img_h(d), 1'b0)));
        end
        show = 1'b1;
        repeat ($urandom_range(3, 8)) step();

        // Restart at (0,0) with show=1 latched; random show toggles mid-frame
        // must have no effect.
        reset    = 1'b1;
        hs_low   = 0;
        bl_hi    = 0;
        fall_cnt = 0;
        hs_prev  = 1'b1;
        for (int i = 0; i < 26 * 1600; i++) begin
            step();
            if (k > 4 && $urandom_range(0, 499) == 0) show = ~show;
        end

        check("hsync_low_clks", 64'(hs_low), 64'd192);
        check("blank_high_clks", 64'(bl_hi), 64'd1280);
        check("hsync_period", 64'(fall_k1 - fall_k0), 64'd1600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
